// File: rtl/adc_level_trigger.sv
`timescale 1ns/1ps
// Analog level trigger: arms on cmd_arm_adc rise, detects a threshold crossing, delays trig_o by trigger_offset, measures time past level.
// Optional hysteresis qualifier is enabled by defining ADC_TRIG_HYSTERESIS_EN.
module adc_level_trigger #(
  parameter int pADC_WIDTH = 12,
  parameter int pHYST      = 16
) (
  input  logic                  adc_sampleclk,
  input  logic                  reset,
  input  logic [pADC_WIDTH-1:0] adc_data,
  input  logic                  cmd_arm_adc,
  input  logic                  trigger_mode,
  input  logic [pADC_WIDTH-1:0] trigger_adclevel,
  input  logic [31:0]           trigger_offset,
  input  logic                  trigger_now,
  output logic                  trig_o,
  output logic                  armed_o,
  output logic [31:0]           trigger_length
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_ARMED,
    S_DELAY,
    S_FIRED
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [pADC_WIDTH-1:0]   adc_cur;
  logic [pADC_WIDTH-1:0]   adc_prev;
  logic                    arm_q;
  logic                    now_q;
  logic [31:0]             delay_cnt;
  logic [31:0]             len_cnt;
  logic                    measuring;
  logic                    arm_edge;
  logic                    cond_hold;
  logic                    level_rule;
  logic                    level_cross;
  logic                    force_cross;
  logic                    any_cross;
  logic                    armed_nxt;

  // adc_prev follows adc_cur every cycle, so by the time PRIME hands over to
  // ARMED it always holds a sample taken after the arm edge.
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      adc_cur  <= '0;
      adc_prev <= '0;
      arm_q    <= 1'b0;
      now_q    <= 1'b0;
    end else begin
      adc_cur  <= adc_data;
      adc_prev <= adc_cur;
      arm_q    <= cmd_arm_adc;
      now_q    <= trigger_now;
    end
  end

  assign arm_edge   = cmd_arm_adc & ~arm_q;
  assign cond_hold  = trigger_mode ? (adc_cur >= trigger_adclevel)
                                   : (adc_cur <= trigger_adclevel);
  assign level_rule = cond_hold & (trigger_mode ? (adc_prev < trigger_adclevel)
                                                : (adc_prev > trigger_adclevel));

`ifdef ADC_TRIG_HYSTERESIS_EN
  localparam logic [pADC_WIDTH:0] HYST_EXT = pHYST[pADC_WIDTH:0];
  localparam logic [pADC_WIDTH:0] FULL_EXT = {1'b0, {pADC_WIDTH{1'b1}}};

  logic [pADC_WIDTH:0] lvl_ext;
  logic [pADC_WIDTH:0] sum_ext;
  logic [pADC_WIDTH:0] band_lo;
  logic [pADC_WIDTH:0] band_hi;
  logic                far_side;
  logic                qual;

  // Band edges are computed one bit wider so they can clamp at 0 and full scale.
  always_comb begin
    lvl_ext  = {1'b0, trigger_adclevel};
    sum_ext  = lvl_ext + HYST_EXT;
    band_lo  = (lvl_ext > HYST_EXT) ? (lvl_ext - HYST_EXT) : '0;
    band_hi  = (sum_ext > FULL_EXT) ? FULL_EXT : sum_ext;
    far_side = trigger_mode ? ({1'b0, adc_cur} < band_lo)
                            : ({1'b0, adc_cur} > band_hi);
  end

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      qual <= 1'b0;
    end else if ((state == S_IDLE && arm_edge) || any_cross) begin
      qual <= 1'b0;
    end else if (far_side) begin
      qual <= 1'b1;
    end
  end

  assign level_cross = (state == S_ARMED) & cmd_arm_adc & level_rule & qual;
`else
  assign level_cross = (state == S_ARMED) & cmd_arm_adc & level_rule;
`endif

  assign force_cross = (state == S_ARMED) & cmd_arm_adc & now_q;
  assign any_cross   = level_cross | force_cross;

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      state   <= S_IDLE;
      armed_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      armed_o <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm_edge) state_nxt = S_PRIME;
      S_PRIME: state_nxt = cmd_arm_adc ? S_ARMED : S_IDLE;
      S_ARMED: begin
        if (!cmd_arm_adc)   state_nxt = S_IDLE;
        else if (any_cross) state_nxt = S_DELAY;
      end
      S_DELAY: begin
        if (!cmd_arm_adc)         state_nxt = S_IDLE;
        else if (delay_cnt == '0) state_nxt = S_FIRED;
      end
      S_FIRED: if (!cmd_arm_adc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Abort (arm low) and reset both override an expiring delay.
  always_comb begin
    trig_o    = (state == S_DELAY) && (delay_cnt == '0) && cmd_arm_adc && !reset;
    armed_nxt = (state_nxt == S_ARMED) || (state_nxt == S_DELAY);
  end

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      delay_cnt <= '0;
    end else if (any_cross) begin
      delay_cnt <= trigger_offset;
    end else if (state == S_DELAY && delay_cnt != '0) begin
      delay_cnt <= delay_cnt - 32'd1;
    end
  end

  // Length measurement ignores the FSM after it starts; only a new arm edge or reset clears it.
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      len_cnt        <= '0;
      measuring      <= 1'b0;
      trigger_length <= '0;
    end else if (state == S_IDLE && arm_edge) begin
      len_cnt        <= '0;
      measuring      <= 1'b0;
      trigger_length <= '0;
    end else if (level_cross) begin
      len_cnt   <= 32'd1;
      measuring <= 1'b1;
    end else if (measuring) begin
      if (cond_hold) begin
        if (len_cnt != '1) len_cnt <= len_cnt + 32'd1;
      end else begin
        trigger_length <= len_cnt;
        measuring      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_level_trigger.sv
`timescale 1ns/1ps
// Directed bench for adc_level_trigger with a timestamp-based reference model checked every cycle.
module tb_adc_level_trigger;

  localparam int W    = 12;
  localparam int HYST = 16;

  logic          adc_sampleclk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  adc_data = '0;
  logic          cmd_arm_adc = 1'b0;
  logic          trigger_mode = 1'b1;
  logic [W-1:0]  trigger_adclevel = 12'h800;
  logic [31:0]   trigger_offset = '0;
  logic          trigger_now = 1'b0;
  logic          trig_o;
  logic          armed_o;
  logic [31:0]   trigger_length;

  adc_level_trigger #(.pADC_WIDTH(W), .pHYST(HYST)) dut (
    .adc_sampleclk    (adc_sampleclk),
    .reset            (reset),
    .adc_data         (adc_data),
    .cmd_arm_adc      (cmd_arm_adc),
    .trigger_mode     (trigger_mode),
    .trigger_adclevel (trigger_adclevel),
    .trigger_offset   (trigger_offset),
    .trigger_now      (trigger_now),
    .trig_o           (trig_o),
    .armed_o          (armed_o),
    .trigger_length   (trigger_length)
  );

  always #5 adc_sampleclk = ~adc_sampleclk;

  int cyc = 0;
  always @(posedge adc_sampleclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int trig_cnt = 0;
  int last_trig = -1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sessions and scheduled fire times rather than a state machine.
  int          m_sess = 0;      // 0 none, 1 armed/pending, 2 fired and waiting for arm low
  int          m_e = 0;         // cycle of the accepted arm edge
  int          m_fire = -1;     // cycle trig_o must appear in
  bit          m_qual = 0;
  bit          m_meas = 0;
  int          m_c = 0;
  int          m_p = 0;
  bit          m_now = 0;
  bit          m_parm = 0;
  longint      m_cnt = 0;
  longint      m_len = 0;
  bit          e_trig, e_armed, hold, rule, window, lc, fc, edge_ev, far;
  int          lvl;

  always @(negedge adc_sampleclk) begin
    e_trig  = !reset && m_sess == 1 && m_fire == cyc && cmd_arm_adc;
    e_armed = m_sess == 1 && cyc >= m_e + 2;
    if (cyc >= 2) begin
      check("trig_o", trig_o, e_trig);
      check("armed_o", armed_o, e_armed);
      check("trigger_length", trigger_length, m_len);
    end
    if (trig_o) begin
      trig_cnt++;
      last_trig = cyc;
    end

    if (reset) begin
      m_sess = 0; m_fire = -1; m_qual = 0; m_meas = 0;
      m_cnt = 0; m_len = 0; m_c = 0; m_p = 0; m_now = 0; m_parm = 0;
    end else begin
      lvl     = int'(trigger_adclevel);
      hold    = trigger_mode ? (m_c >= lvl) : (m_c <= lvl);
      rule    = hold && (trigger_mode ? (m_p < lvl) : (m_p > lvl));
      window  = m_sess == 1 && cyc >= m_e + 2 && m_fire < 0 && cmd_arm_adc;
`ifdef ADC_TRIG_HYSTERESIS_EN
      lc      = window && rule && m_qual;
`else
      lc      = window && rule;
`endif
      fc      = window && m_now;
      edge_ev = m_sess == 0 && cmd_arm_adc && !m_parm;
      far     = trigger_mode ? (m_c < lvl - HYST) : (m_c > lvl + HYST);

      if (edge_ev || lc || fc) m_qual = 0;
      else if (far)            m_qual = 1;

      if (edge_ev) begin
        m_sess = 1; m_e = cyc; m_fire = -1;
      end else if (m_sess == 1) begin
        if (!cmd_arm_adc) begin
          m_sess = 0; m_fire = -1;
        end else if (m_fire >= 0) begin
          if (cyc == m_fire) m_sess = 2;
        end else if (lc || fc) begin
          m_fire = cyc + 1 + int'(trigger_offset);
        end
      end else if (m_sess == 2 && !cmd_arm_adc) begin
        m_sess = 0;
      end

      if (edge_ev) begin
        m_meas = 0; m_cnt = 0; m_len = 0;
      end else if (lc) begin
        m_meas = 1; m_cnt = 1;
      end else if (m_meas) begin
        if (hold) begin
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else begin
          m_len = m_cnt; m_meas = 0;
        end
      end

      m_p = m_c; m_c = int'(adc_data); m_now = trigger_now; m_parm = cmd_arm_adc;
    end
  end

  task automatic tick(input logic [W-1:0] d);
    @(posedge adc_sampleclk);
    #1;
    adc_data = d;
  endtask

  task automatic ticks(input logic [W-1:0] d, input int n);
    repeat (n) tick(d);
  endtask

  int n0, t_n, t_e, t_d;

  initial begin
    reset = 1'b1;
    ticks(12'h000, 3);
    reset = 1'b0;
    tick(12'h000);
    check("rst_trig", trig_o, 0);
    check("rst_armed", armed_o, 0);
    check("rst_len", trigger_length, 0);

    // Rising, L=0x800, offset 0
    trigger_mode = 1'b1; trigger_adclevel = 12'h800; trigger_offset = 0;
    tick(12'h700);
    cmd_arm_adc = 1'b1; t_e = cyc;
    tick(12'h700);
    check("t1_armed_e1", armed_o, 0);
    tick(12'h700);
    check("t1_armed_e2", armed_o, 1);
    n0 = trig_cnt;
    tick(12'h7FF);
    tick(12'h800); t_n = cyc;
    ticks(12'h900, 10);
    ticks(12'h100, 3);
    check("t1_len", trigger_length, 11);
    check("t1_trig_count", trig_cnt - n0, 1);
    check("t1_trig_cycle", last_trig, t_n + 2);
    cmd_arm_adc = 1'b0;
    ticks(12'h100, 2);

    // Falling, L=0x400, offset 5
    trigger_mode = 1'b0; trigger_adclevel = 12'h400; trigger_offset = 5;
    tick(12'h500);
    cmd_arm_adc = 1'b1;
    ticks(12'h500, 3);
    n0 = trig_cnt;
    tick(12'h3FF); t_n = cyc;
    ticks(12'h3FF, 6);
    ticks(12'h500, 4);
    check("t2_trig_count", trig_cnt - n0, 1);
    check("t2_trig_cycle", last_trig, t_n + 7);
    check("t2_len", trigger_length, 7);
    cmd_arm_adc = 1'b0;
    ticks(12'h500, 2);

    // Abort 50 cycles after the crossing, measurement keeps running, then re-arm
    trigger_mode = 1'b1; trigger_adclevel = 12'h800; trigger_offset = 100;
    tick(12'h100);
    cmd_arm_adc = 1'b1;
    ticks(12'h100, 3);
    n0 = trig_cnt;
    tick(12'h900); t_n = cyc;
    ticks(12'h900, 50);
    tick(12'h900);
    cmd_arm_adc = 1'b0; t_d = cyc;
    check("t3_armed_before", armed_o, 1);
    tick(12'h900);
    check("t3_armed_after", armed_o, 0);
    ticks(12'h900, 60);
    ticks(12'h100, 3);
    check("t3_no_trig", trig_cnt - n0, 0);
    check("t3_len", trigger_length, 113);
    check("t3_abort_cycle", t_d, t_n + 51);
    ticks(12'h100, 2);
    trigger_offset = 3;
    cmd_arm_adc = 1'b1;
    ticks(12'h100, 3);
    n0 = trig_cnt;
    tick(12'h900); t_n = cyc;
    ticks(12'h900, 3);
    ticks(12'h100, 4);
    check("t3_rearm_count", trig_cnt - n0, 1);
    check("t3_rearm_cycle", last_trig, t_n + 5);
    check("t3_rearm_len", trigger_length, 4);
    cmd_arm_adc = 1'b0;
    ticks(12'h100, 2);

    // Forced trigger on a flat input
    trigger_offset = 0;
    tick(12'h000);
    cmd_arm_adc = 1'b1;
    ticks(12'h000, 3);
    n0 = trig_cnt;
    tick(12'h000);
    trigger_now = 1'b1; t_n = cyc;
    tick(12'h000);
    trigger_now = 1'b0;
    ticks(12'h000, 4);
    check("t4_trig_count", trig_cnt - n0, 1);
    check("t4_trig_cycle", last_trig, t_n + 2);
    check("t4_len", trigger_length, 0);
    cmd_arm_adc = 1'b0;
    ticks(12'h000, 2);

    // Armed while already past the level
    ticks(12'hFFF, 3);
    n0 = trig_cnt;
    cmd_arm_adc = 1'b1;
    ticks(12'hFFF, 10);
    check("t5_no_early", trig_cnt - n0, 0);
    tick(12'h700);
    tick(12'h900); t_n = cyc;
    ticks(12'h900, 3);
    check("t5_trig_count", trig_cnt - n0, 1);
    check("t5_trig_cycle", last_trig, t_n + 2);
    cmd_arm_adc = 1'b0;
    ticks(12'h100, 2);

    // Noise around the level
    tick(12'h7F5);
    cmd_arm_adc = 1'b1;
    ticks(12'h7F5, 3);
    n0 = trig_cnt;
    for (int i = 0; i < 10; i++) begin
      tick(12'h805);
      tick(12'h7F5);
    end
    tick(12'h7F5);
`ifdef ADC_TRIG_HYSTERESIS_EN
    check("t6_noise_quiet", trig_cnt - n0, 0);
    tick(12'h7EF);
    tick(12'h800); t_n = cyc;
    ticks(12'h800, 3);
    check("t6_dip_count", trig_cnt - n0, 1);
    check("t6_dip_cycle", last_trig, t_n + 2);
`else
    check("t6_noise_fires", trig_cnt - n0, 1);
`endif
    cmd_arm_adc = 1'b0;
    ticks(12'h100, 2);

    // Reset in the middle of a long delay
    trigger_offset = 20;
    tick(12'h100);
    cmd_arm_adc = 1'b1;
    ticks(12'h100, 3);
    n0 = trig_cnt;
    tick(12'h900);
    ticks(12'h900, 2);
    ticks(12'h100, 5);
    check("t7_len_before", trigger_length, 3);
    check("t7_armed_before", armed_o, 1);
    reset = 1'b1; cmd_arm_adc = 1'b0;
    ticks(12'h100, 2);
    reset = 1'b0;
    ticks(12'h100, 25);
    check("t7_no_trig", trig_cnt - n0, 0);
    check("t7_len_cleared", trigger_length, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, limit 20000", cyc);
    $fatal(1);
  end

endmodule
